right_shift_sequencer: RTL and testbench
========================================

RIGHT_SHIFT_SEQUENCER -- requirements
Module: right_shift_sequencer

Interface
REQ-001 Parameter: width, 16, data width; power of two, >= 4.
REQ-002 Derived constant: AW = log2(width), the shift-amount width (4 for width=16).
REQ-003 Port: clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request to begin a shift operation.
REQ-006 Port: din  input  width  operand to shift.
REQ-007 Port: amount  input  AW  number of 1-bit right shifts, 0..width-1.
REQ-008 Port: mode  input  1  shift type: 0 = arithmetic, 1 = logical.
REQ-009 Port: busy  output  1  high while an operation is in progress (SHIFT or DONE state).
REQ-010 Port: out_valid  output  1  dout holds a completed result.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: dout  output  width  shift result / working register.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 In IDLE with start=1, the block SHALL capture din into dout, amount into a down-counter, and mode into an internal register at that edge.
REQ-015 The IDLE exit SHALL go to DONE if the captured amount = 0, otherwise to SHIFT.
REQ-016 In SHIFT, each clock SHALL shift dout right by one bit.
- mode=0: MSB replicated (dout <= {dout[width-1], dout[width-1:1]}).
- mode=1: zero fill (dout <= {1'b0, dout[width-1:1]}).
- The counter decrements by 1 on each such shift.
REQ-017 The block SHALL leave SHIFT for DONE on the edge that performs the final shift, when the counter goes 1 -> 0.
REQ-018 Latency: if start is sampled in cycle t, out_valid SHALL first be high in cycle t+amount+1, with exactly amount shifts applied.
REQ-019 In DONE, out_valid SHALL be 1 and dout SHALL hold stable until out_ready=1 is sampled; the FSM then returns to IDLE on that edge.
REQ-020 out_valid SHALL be 0 in IDLE and SHIFT.
REQ-021 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-022 start SHALL be ignored in SHIFT and DONE.
- This includes start asserted in the same cycle as the accepting out_ready; it must be re-presented in IDLE.
REQ-023 Changes on din, amount, or mode after capture SHALL NOT affect an operation in progress.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 dout SHALL retain its last value in IDLE until the next capture.
REQ-026 Boundary: amount = width-1 in arithmetic mode SHALL yield all-ones for a negative operand and all-zeros for a non-negative one.
REQ-027 Boundary: amount = width-1 in logical mode SHALL yield the original MSB in bit 0.
REQ-028 Boundary: for amount = 0, dout SHALL equal din unchanged in the DONE state.

Reset
REQ-029 reset=1 sampled at an edge SHALL force, on that edge: state = IDLE, dout = 0, counter = 0, stored mode = 0, out_valid = 0, busy = 0.
REQ-030 Reset SHALL take priority over start, out_ready, and any in-progress SHIFT or DONE; a reset mid-operation discards the operation.
REQ-031 There SHALL be no asynchronous reset path.

Verification (width=16)
REQ-032 Arithmetic shift: start with din=16'h8000, amount=4, mode=0 in cycle t -> out_valid rises in cycle t+5 with dout=16'hF800.
REQ-033 Logical shift: same stimulus with mode=1 -> dout=16'h0800 in cycle t+5.
REQ-034 Zero amount: din=16'h1234, amount=0 -> out_valid in cycle t+1 with dout=16'h1234.
REQ-035 Maximum amount: din=16'h8001, amount=15 -> dout=16'hFFFF with mode=0, and dout=16'h0001 with mode=1, in cycle t+16.
REQ-036 Backpressure: out_ready held low 3 cycles in DONE while start pulses -> dout stable, out_valid stays 1, no new capture; after out_ready=1, IDLE next cycle with busy=0.
REQ-037 Reset mid-operation: reset pulsed during SHIFT with amount=10 -> next cycle busy=0, out_valid=0, dout=16'h0000, and a fresh start is accepted normally.

Source files
------------

// File: rtl/right_shift_sequencer.sv
// Multi-cycle right shifter: captures an operand, shifts it one bit per clock
// (arithmetic or logical), then holds the result under a valid/ready handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; dout keeps the last result
// SHIFT | one right shift per clock until the down-counter reaches 0
// DONE  | result valid on dout; held until out_ready is sampled high
module right_shift_sequencer #(
  parameter  int width = 16,
  localparam int AW    = $clog2(width)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] din,
  input  logic [AW-1:0]    amount,
  input  logic             mode,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic            mode_q;
  logic            capture;
  logic            last_shift;
  logic            fill_bit;

  // A capture only happens from IDLE, so start is ignored while busy.
  assign capture    = (state == IDLE) && start;
  // Terminal count: the shift performed at this edge is the final one.
  assign last_shift = (cnt == AW'(1));
  // mode_q: 0 replicates the sign bit, 1 shifts in zeros.
  assign fill_bit   = mode_q ? 1'b0 : dout[width-1];

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (amount == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand/amount/mode capture, then one shift and decrement per SHIFT clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout   <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else if (capture) begin
      dout   <= din;
      cnt    <= amount;
      mode_q <= mode;
    end else if (state == SHIFT) begin
      dout <= {fill_bit, dout[width-1:1]};
      cnt  <= cnt - AW'(1);
    end
  end

endmodule

// File: tb/tb_right_shift_sequencer.sv
// Bench for right_shift_sequencer (width=16): table of shift vectors pushed
// through a scoreboard queue, plus hand-written backpressure and reset sequences.
module tb_right_shift_sequencer;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  din;
  logic [AW-1:0] amount;
  logic          mode;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dout;

  right_shift_sequencer #(.width(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .amount    (amount),
    .mode      (mode),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  din;
    logic [AW-1:0] amount;
    logic          mode;
    logic [W-1:0]  exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] dout;
    int           lat;
  } sb_t;

  vec_t vecs[11];
  sb_t  sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: start, wait for out_valid, compare against the
  // scoreboard, then accept. hold_ready drives out_ready high during SHIFT.
  task automatic run_vec(input vec_t v, input bit hold_ready);
    sb_t exp_e;
    sb_t got_e;
    int  cycles;
    exp_e.dout = v.exp;
    exp_e.lat  = int'(v.amount) + 1;
    sb_q.push_back(exp_e);
    din       = v.din;
    amount    = v.amount;
    mode      = v.mode;
    start     = 1'b1;
    out_ready = hold_ready;
    tick();
    start  = 1'b0;
    din    = W'($urandom);
    amount = AW'($urandom);
    mode   = 1'($urandom);
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      check("busy_in_shift", busy, 1);
      tick();
      cycles++;
    end
    check("valid_seen", out_valid, 1);
    if (out_valid) begin
      check("sb_not_empty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        got_e = sb_q.pop_front();
        check("dout", dout, got_e.dout);
        check("latency", cycles, got_e.lat);
      end
      check("busy_in_done", busy, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_busy", busy, 0);
      check("idle_valid", out_valid, 0);
      check("idle_dout_held", dout, v.exp);
    end
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{16'h8000, 4'd4,  1'b0, 16'hF800};
    vecs[1]  = '{16'h8000, 4'd4,  1'b1, 16'h0800};
    vecs[2]  = '{16'h1234, 4'd0,  1'b0, 16'h1234};
    vecs[3]  = '{16'h8001, 4'd15, 1'b0, 16'hFFFF};
    vecs[4]  = '{16'h8001, 4'd15, 1'b1, 16'h0001};
    vecs[5]  = '{16'h7FFF, 4'd15, 1'b0, 16'h0000};
    vecs[6]  = '{16'hA5C3, 4'd1,  1'b0, 16'hD2E1};
    vecs[7]  = '{16'hA5C3, 4'd1,  1'b1, 16'h52E1};
    vecs[8]  = '{16'h4F00, 4'd8,  1'b0, 16'h004F};
    vecs[9]  = '{16'hC3A0, 4'd3,  1'b0, 16'hF874};
    vecs[10] = '{16'hC3A0, 4'd3,  1'b1, 16'h1874};

    reset = 1'b1; start = 1'b0; din = '0; amount = '0; mode = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_dout", dout, 16'h0000);
    reset = 1'b0;

    // out_ready in IDLE must do nothing
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_ready_ignored", busy, 0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], (i % 2) == 1);

    // Backpressure: DONE holds while start pulses with a different operand.
    v = '{16'h8000, 4'd4, 1'b0, 16'hF800};
    din = v.din; amount = v.amount; mode = v.mode; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("bp_valid_rise", out_valid, 1);
    din = 16'h1111; amount = 4'd2; mode = 1'b1;
    for (int c = 0; c < 3; c++) begin
      start = (c % 2) == 0;
      tick();
      check("bp_valid_hold", out_valid, 1);
      check("bp_dout_hold", dout, 16'hF800);
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    check("bp_accept_busy", busy, 0);
    check("bp_accept_valid", out_valid, 0);
    tick();
    check("bp_start_dropped", busy, 0);
    check("bp_dout_retained", dout, 16'hF800);

    // Reset during SHIFT, with start also high to confirm reset priority.
    din = 16'hABCD; amount = 4'd10; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_busy_before_rst", busy, 1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_dout", dout, 16'h0000);
    tick();
    check("mid_rst_stays_idle", busy, 0);
    run_vec('{16'h0F0F, 4'd2, 1'b1, 16'h03C3}, 1'b0);

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
